// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Shared op/return encodings and link_sif width helpers for the memory responder endpoint.
package bsg_manycore_mem_responder_pkg;

  localparam int reg_id_width_gp = 5;

  typedef enum logic [1:0] {
    e_remote_load  = 2'd0,
    e_remote_store = 2'd1,
    e_remote_amo   = 2'd2,
    e_cache_op     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_ifetch   = 2'd3
  } return_type_e;

  // Request: addr, op, op_ex, reg_id, payload, src_y, src_x, y_cord, x_cord (MSB first)
  function automatic int packet_width(int a, int d, int x, int y);
    return a + 2 + d / 8 + reg_id_width_gp + d + 2 * y + 2 * x;
  endfunction

  // Return: pkt_type, data, reg_id, src_y, src_x, y_cord, x_cord (MSB first)
  function automatic int return_packet_width(int d, int x, int y);
    return 2 + d + reg_id_width_gp + 2 * y + 2 * x;
  endfunction

  // Each direction carries {v, packet, ready_and_rev}; forward half sits above reverse half.
  function automatic int bsg_manycore_link_sif_width(int a, int d, int x, int y);
    return packet_width(a, d, x, y) + return_packet_width(d, x, y) + 4;
  endfunction

endpackage

// File: rtl/bsg_manycore_mem_responder_fifo.sv
// Two-entry ready/valid FIFO; ready is held low while reset is asserted.
module bsg_manycore_mem_responder_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  assign ready_o = reset_n_i & (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_mem_responder_mem.sv
// Single-port synchronous RAM with per-byte write mask; contents survive reset.
module bsg_manycore_mem_responder_mem #(
  parameter int width_p  = 32,
  parameter int els_p    = 64,
  parameter int lg_els_p = 6
) (
  input  logic                  clk_i,
  input  logic                  v_i,
  input  logic                  w_i,
  input  logic [lg_els_p-1:0]   addr_i,
  input  logic [width_p-1:0]    data_i,
  input  logic [width_p/8-1:0]  write_mask_i,
  output logic [width_p-1:0]    data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) data_o <= mem_r[addr_i];
    if (v_i & w_i) begin
      for (int i = 0; i < width_p / 8; i++) begin
        if (write_mask_i[i]) mem_r[addr_i][8*i +: 8] <= data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Terminating manycore endpoint: serves remote loads/stores from local memory, one response per request.
module bsg_manycore_mem_responder
  import bsg_manycore_mem_responder_pkg::*;
#(
  parameter int addr_width_p   = 8,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 3,
  parameter int mem_els_p      = 64,
  localparam int link_sif_width_lp = bsg_manycore_link_sif_width(
    addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  output logic                         error_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int lg_mem_els_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam logic [addr_width_p:0] mem_els_lim_lp = (addr_width_p + 1)'(mem_els_p);

  typedef enum logic {e_idle, e_resp} state_e;

  typedef struct packed {
    logic [addr_width_p-1:0]    addr;
    logic [1:0]                 op;
    logic [mask_width_lp-1:0]   op_ex;
    logic [reg_id_width_gp-1:0] reg_id;
    logic [data_width_p-1:0]    payload;
    logic [y_cord_width_p-1:0]  src_y;
    logic [x_cord_width_p-1:0]  src_x;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } packet_s;

  typedef struct packed {
    logic [1:0]                 pkt_type;
    logic [data_width_p-1:0]    data;
    logic [reg_id_width_gp-1:0] reg_id;
    logic [y_cord_width_p-1:0]  src_y;
    logic [x_cord_width_p-1:0]  src_x;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } return_packet_s;

  typedef struct packed {logic v; packet_s data; logic ready_and_rev;} fwd_link_s;
  typedef struct packed {logic v; return_packet_s data; logic ready_and_rev;} rev_link_s;
  typedef struct packed {fwd_link_s fwd; rev_link_s rev;} link_sif_s;

  link_sif_s link_in;
  link_sif_s link_out;
  assign link_in    = link_sif_i;
  assign link_sif_o = link_out;

  logic                    fifo_v;
  logic                    fifo_ready;
  logic                    fifo_yumi;
  logic [$bits(packet_s)-1:0] fifo_data;
  packet_s                 req;

  bsg_manycore_mem_responder_fifo #(.width_p($bits(packet_s))) fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (link_in.fwd.v),
    .data_i   (link_in.fwd.data),
    .ready_o  (fifo_ready),
    .v_o      (fifo_v),
    .data_o   (fifo_data),
    .yumi_i   (fifo_yumi)
  );
  assign req = fifo_data;

  state_e                     state_r;
  logic [1:0]                 resp_type_r;
  logic [reg_id_width_gp-1:0] resp_reg_id_r;
  logic [x_cord_width_p-1:0]  dest_x_r;
  logic [y_cord_width_p-1:0]  dest_y_r;
  logic [x_cord_width_p-1:0]  src_x_r;
  logic [y_cord_width_p-1:0]  src_y_r;
  logic                       load_ok_r;
  logic                       error_r;

  logic                    is_load;
  logic                    is_store;
  logic                    in_range;
  logic                    access;
  logic                    access_err;
  logic [data_width_p-1:0] mem_data;

  assign is_load    = (req.op == e_remote_load);
  assign is_store   = (req.op == e_remote_store);
  assign in_range   = ({1'b0, req.addr} < mem_els_lim_lp);
  assign access     = (state_r == e_idle) & fifo_v;
  assign fifo_yumi  = access;
  assign access_err = access & (~in_range | ~(is_load | is_store));

  // Out-of-range and unknown ops never touch the array; the response is still produced.
  bsg_manycore_mem_responder_mem #(
    .width_p (data_width_p),
    .els_p   (mem_els_p),
    .lg_els_p(lg_mem_els_lp)
  ) mem (
    .clk_i       (clk_i),
    .v_i         (access & in_range & (is_load | is_store)),
    .w_i         (is_store),
    .addr_i      (req.addr[lg_mem_els_lp-1:0]),
    .data_i      (req.payload),
    .write_mask_i(req.op_ex),
    .data_o      (mem_data)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r       <= e_idle;
      resp_type_r   <= e_return_credit;
      resp_reg_id_r <= '0;
      dest_x_r      <= '0;
      dest_y_r      <= '0;
      src_x_r       <= '0;
      src_y_r       <= '0;
      load_ok_r     <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      error_r <= error_r | access_err | link_in.rev.v;
      case (state_r)
        e_idle: if (fifo_v) begin
          state_r       <= e_resp;
          resp_type_r   <= is_load ? e_return_int_wb : e_return_credit;
          resp_reg_id_r <= req.reg_id;
          dest_x_r      <= req.src_x;
          dest_y_r      <= req.src_y;
          src_x_r       <= my_x_i;
          src_y_r       <= my_y_i;
          load_ok_r     <= is_load & in_range;
        end
        e_resp: if (link_in.rev.ready_and_rev) state_r <= e_idle;
        default: state_r <= e_idle;
      endcase
    end
  end

  // Read data is taken straight from the RAM register; it holds because the RAM idles in RESP.
  always_comb begin
    link_out                      = '0;
    link_out.fwd.ready_and_rev    = fifo_ready;
    link_out.rev.ready_and_rev    = 1'b1;
    link_out.rev.v                = (state_r == e_resp);
    link_out.rev.data.pkt_type    = resp_type_r;
    link_out.rev.data.data        = load_ok_r ? mem_data : '0;
    link_out.rev.data.reg_id      = resp_reg_id_r;
    link_out.rev.data.src_y       = src_y_r;
    link_out.rev.data.src_x       = src_x_r;
    link_out.rev.data.y_cord      = dest_y_r;
    link_out.rev.data.x_cord      = dest_x_r;
  end

  assign error_o = error_r;

  logic unused_bits;
  assign unused_bits = ^{link_in.fwd.ready_and_rev, link_in.rev.data, req.y_cord, req.x_cord};

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Directed and randomized bench for the manycore memory responder with an in-order response scoreboard.
module tb_bsg_manycore_mem_responder;
  import bsg_manycore_mem_responder_pkg::*;

  localparam int A  = 8;
  localparam int D  = 32;
  localparam int X  = 4;
  localparam int Y  = 3;
  localparam int N  = 64;
  localparam int LW = bsg_manycore_link_sif_width(A, D, X, Y);
  localparam int RW = return_packet_width(D, X, Y);

  typedef struct packed {
    logic [A-1:0]   addr;
    logic [1:0]     op;
    logic [D/8-1:0] op_ex;
    logic [4:0]     reg_id;
    logic [D-1:0]   payload;
    logic [Y-1:0]   src_y;
    logic [X-1:0]   src_x;
    logic [Y-1:0]   y_cord;
    logic [X-1:0]   x_cord;
  } packet_s;

  typedef struct packed {
    logic [1:0]   pkt_type;
    logic [D-1:0] data;
    logic [4:0]   reg_id;
    logic [Y-1:0] src_y;
    logic [X-1:0] src_x;
    logic [Y-1:0] y_cord;
    logic [X-1:0] x_cord;
  } return_packet_s;

  typedef struct packed {logic v; packet_s data; logic ready_and_rev;} fwd_link_s;
  typedef struct packed {logic v; return_packet_s data; logic ready_and_rev;} rev_link_s;
  typedef struct packed {fwd_link_s fwd; rev_link_s rev;} link_sif_s;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [X-1:0] my_x = 4'd1;
  logic [Y-1:0] my_y = 3'd2;

  logic           fwd_v = 1'b0;
  packet_s        fwd_pkt = '0;
  logic           stray_v = 1'b0;
  return_packet_s stray_pkt = '0;
  logic           ready_drv = 1'b1;
  logic           rand_en = 1'b0;
  logic           rand_bit = 1'b1;
  logic           rev_ready;
  logic [LW-1:0]  lin_v;
  logic [LW-1:0]  lout_v;
  link_sif_s      lout;
  logic           error;

  assign rev_ready = rand_en ? rand_bit : ready_drv;
  assign lin_v     = {fwd_v, fwd_pkt, 1'b1, stray_v, stray_pkt, rev_ready};
  assign lout      = lout_v;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  bsg_manycore_mem_responder #(
    .addr_width_p  (A),
    .data_width_p  (D),
    .x_cord_width_p(X),
    .y_cord_width_p(Y),
    .mem_els_p     (N)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .link_sif_i(lin_v),
    .link_sif_o(lout_v),
    .my_x_i    (my_x),
    .my_y_i    (my_y),
    .error_o   (error)
  );

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic [D-1:0]  model_mem [N];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && lout.rev.v && rev_ready) begin
      check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("resp_pkt", 64'(lout.rev.data), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [A-1:0] addr, input logic [1:0] op, input logic [3:0] mask,
                          input logic [4:0] reg_id, input logic [D-1:0] data,
                          input logic [X-1:0] sx, input logic [Y-1:0] sy);
    return_packet_s r;
    logic hs;
    logic ok;
    ok = (addr < A'(N));
    r.pkt_type = (op == e_remote_load) ? e_return_int_wb : e_return_credit;
    r.data     = (op == e_remote_load && ok) ? model_mem[addr[5:0]] : '0;
    r.reg_id   = reg_id;
    r.src_y    = my_y;
    r.src_x    = my_x;
    r.y_cord   = sy;
    r.x_cord   = sx;
    exp_q.push_back(r);
    if (op == e_remote_store && ok) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) model_mem[addr[5:0]][8*i +: 8] = data[8*i +: 8];
    end
    fwd_pkt = '{addr: addr, op: op, op_ex: mask, reg_id: reg_id, payload: data,
                src_y: sy, src_x: sx, y_cord: my_y, x_cord: my_x};
    fwd_v = 1'b1;
    hs = 1'b0;
    for (int n = 0; n < 100 && !hs; n++) begin
      @(negedge clk);
      if (lout.fwd.ready_and_rev) hs = 1'b1;
      @(posedge clk);
      #1;
    end
    fwd_v = 1'b0;
    check("send_handshake", 64'(hs), 64'd1);
  endtask

  task automatic store(input logic [A-1:0] addr, input logic [D-1:0] data, input logic [3:0] mask,
                       input logic [X-1:0] sx, input logic [Y-1:0] sy);
    send_req(addr, e_remote_store, mask, 5'd0, data, sx, sy);
  endtask

  task automatic load(input logic [A-1:0] addr, input logic [4:0] reg_id,
                      input logic [X-1:0] sx, input logic [Y-1:0] sy);
    send_req(addr, e_remote_load, 4'h0, reg_id, 32'h0, sx, sy);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_rev_v", 64'(lout.rev.v), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_fwd_ready", 64'(lout.fwd.ready_and_rev), 64'd0);
    check("fwd_out_idle", 64'({lout.fwd.v, lout.fwd.data}), 64'd0);
    check("rev_ready_out", 64'(lout.rev.ready_and_rev), 64'd1);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_fwd_ready", 64'(lout.fwd.ready_and_rev), 64'd1);
    step();

    // fill a working set so later loads have known contents
    for (int a = 0; a < 16; a++) store(A'(a), $urandom(), 4'hF, 4'd0, 3'd0);
    drain("drain_fill");

    // store then load with latency checks
    store(8'd5, 32'hDEADBEEF, 4'hF, 4'd2, 3'd0);
    @(negedge clk);
    check("store_lat_t1", 64'(lout.rev.v), 64'd0);
    @(negedge clk);
    check("store_lat_t2", 64'(lout.rev.v), 64'd1);
    step();
    load(8'd5, 5'd3, 4'd2, 3'd0);
    @(negedge clk);
    check("load_lat_t1", 64'(lout.rev.v), 64'd0);
    @(negedge clk);
    check("load_lat_t2", 64'(lout.rev.v), 64'd1);
    step();
    drain("drain_st_ld");

    // byte mask
    store(8'd7, 32'hAAAAAAAA, 4'hF, 4'd3, 3'd1);
    store(8'd7, 32'h11223344, 4'b0101, 4'd3, 3'd1);
    load(8'd7, 5'd5, 4'd3, 3'd1);
    drain("drain_mask");

    // back-pressure: three loads with reverse ready held low
    ready_drv = 1'b0;
    load(8'd5, 5'd1, 4'd2, 3'd0);
    load(8'd7, 5'd2, 4'd2, 3'd0);
    load(8'd0, 5'd3, 4'd2, 3'd0);
    @(negedge clk);
    check("bp_fwd_ready_full", 64'(lout.fwd.ready_and_rev), 64'd0);
    for (int c = 0; c < 7; c++) begin
      check("bp_hold_v", 64'(lout.rev.v), 64'd1);
      check("bp_hold_pkt", 64'(lout.rev.data), 64'(exp_q[0]));
      @(negedge clk);
    end
    step();
    ready_drv = 1'b1;
    drain("drain_bp");
    @(negedge clk);
    check("bp_fwd_ready_after", 64'(lout.fwd.ready_and_rev), 64'd1);
    step();

    // out-of-range load
    load(8'(N), 5'd1, 4'd3, 3'd1);
    @(negedge clk);
    check("oor_err_before", 64'(error), 64'd0);
    @(negedge clk);
    check("oor_err_set", 64'(error), 64'd1);
    step();
    drain("drain_oor");
    repeat (3) step();
    check("oor_err_sticky", 64'(error), 64'd1);

    // randomized mix with random reverse back-pressure
    rand_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1)
        store(A'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      else
        load(A'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
             4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end
    drain("drain_rand");
    rand_en = 1'b0;
    step();

    // reset with one response pending and two requests queued
    ready_drv = 1'b0;
    load(8'd1, 5'd1, 4'd1, 3'd1);
    load(8'd2, 5'd2, 4'd1, 3'd1);
    load(8'd3, 5'd3, 4'd1, 3'd1);
    @(negedge clk);
    check("mid_pending_v", 64'(lout.rev.v), 64'd1);
    step();
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_fwd_ready", 64'(lout.fwd.ready_and_rev), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    ready_drv = 1'b1;
    @(negedge clk);
    check("mid_post_error", 64'(error), 64'd0);
    check("mid_post_fwd_ready", 64'(lout.fwd.ready_and_rev), 64'd1);
    for (int c = 0; c < 4; c++) begin
      check("mid_post_rev_v", 64'(lout.rev.v), 64'd0);
      @(negedge clk);
    end
    step();
    load(8'd5, 5'd4, 4'd1, 3'd1);
    drain("drain_mid");

    // stray reverse packet
    stray_pkt = '{pkt_type: 2'd1, data: 32'h0BAD0BAD, reg_id: 5'd9, src_y: 3'd0, src_x: 4'd0,
                  y_cord: my_y, x_cord: my_x};
    stray_v = 1'b1;
    @(negedge clk);
    check("stray_ready", 64'(lout.rev.ready_and_rev), 64'd1);
    check("stray_err_before", 64'(error), 64'd0);
    step();
    stray_v = 1'b0;
    @(negedge clk);
    check("stray_err_set", 64'(error), 64'd1);
    step();

    // unknown op answers with a credit and leaves memory alone
    send_req(8'd6, e_remote_amo, 4'hF, 5'd0, 32'h12345678, 4'd2, 3'd2);
    load(8'd6, 5'd7, 4'd2, 3'd2);
    drain("drain_unknown");
    check("unknown_err", 64'(error), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
